// File: rtl/fp16_pkg.sv
// Shared binary16 constants and the sequencer state type used by the FP16
// producers in the floating-point unit.
package fp16_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fp16_pack_rne.sv
// Packs a normalized 16-bit magnitude (bit 15 set) with sign and biased
// exponent into binary16, rounding to nearest-even.
module fp16_pack_rne
  import fp16_pkg::*;
(
  input  logic        sign_i,
  input  logic [4:0]  exp_i,
  input  logic [15:0] mag_i,
  output logic [15:0] fp_o,
  output logic        inexact_o,
  output logic        overflow_o
);

  function automatic logic rne_up(input logic g, input logic s, input logic lsb);
    return g & (s | lsb);
  endfunction

  logic [FP16_MAN_W-1:0]            man;
  logic                             guard;
  logic                             sticky;
  logic [FP16_EXP_W+FP16_MAN_W-1:0] exp_man;

  // Bit 15 is the hidden one; a mantissa carry ripples into the exponent.
  always_comb begin
    man        = mag_i[14:5];
    guard      = mag_i[4];
    sticky     = |mag_i[3:0];
    exp_man    = {exp_i, man} + 15'(rne_up(guard, sticky, mag_i[5]));
    overflow_o = (exp_man[14:10] == {FP16_EXP_W{1'b1}});
    inexact_o  = guard | sticky;
    fp_o       = overflow_o ? {sign_i, {FP16_EXP_W{1'b1}}, {FP16_MAN_W{1'b0}}}
                            : {sign_i, exp_man};
  end

endmodule

// File: rtl/fp_int2fp_seq.sv
// Sequential integer-to-binary16 converter: normalizes one bit per cycle,
// then rounds to nearest-even. One conversion in flight at a time.
module fp_int2fp_seq
  import fp16_pkg::*;
#(
  parameter int INT_W  = 16,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_int,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_fp,
  output logic             out_inexact,
  output logic             out_overflow
);

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [4:0]  exp_q, exp_d;
  logic [15:0] mag_q, mag_d;
  logic [15:0] fp_q, fp_d;
  logic        inexact_q, inexact_d;
  logic        ovf_q, ovf_d;

  logic             neg;
  logic [INT_W-1:0] abs_v;
  logic [15:0]      mag_in;
  logic [15:0]      pk_fp;
  logic             pk_inexact;
  logic             pk_ovf;

  // The most negative signed input negates to 2^(INT_W-1), which still fits
  // once treated as unsigned.
  assign neg    = (SIGNED != 0) && in_int[INT_W-1];
  assign abs_v  = neg ? ((~in_int) + INT_W'(1)) : in_int;
  assign mag_in = 16'(abs_v);

  fp16_pack_rne u_pack (
    .sign_i    (sign_q),
    .exp_i     (exp_q),
    .mag_i     (mag_q),
    .fp_o      (pk_fp),
    .inexact_o (pk_inexact),
    .overflow_o(pk_ovf)
  );

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mag_d     = mag_q;
    fp_d      = fp_q;
    inexact_d = inexact_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = neg;
          mag_d  = mag_in;
          exp_d  = 5'(2 * FP16_BIAS);
          if (mag_in == 16'h0000) begin
            fp_d      = FP16_ZERO;
            inexact_d = 1'b0;
            ovf_d     = 1'b0;
            state_d   = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (!mag_q[15]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 5'd1;
        end else begin
          fp_d      = pk_fp;
          inexact_d = pk_inexact;
          ovf_d     = pk_ovf;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fp_q      <= FP16_ZERO;
      inexact_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fp_q      <= fp_d;
      inexact_q <= inexact_d;
      ovf_q     <= ovf_d;
    end
  end

  // Working operand registers are only meaningful once a request is accepted.
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    exp_q  <= exp_d;
    mag_q  <= mag_d;
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_fp       = fp_q;
  assign out_inexact  = inexact_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_fp_int2fp_seq.sv
// Bench for fp_int2fp_seq: one signed and one unsigned 16-bit instance,
// directed corner cases plus randomized operands against an arithmetic model.
module tb_fp_int2fp_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  in_valid = 2'b00;
  logic [1:0]  in_ready;
  logic [15:0] in_int [2];
  logic [1:0]  out_valid;
  logic [1:0]  out_ready = 2'b00;
  logic [15:0] out_fp [2];
  logic [1:0]  out_inexact;
  logic [1:0]  out_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_int2fp_seq #(.INT_W(16), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_int(in_int[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_fp(out_fp[0]),
    .out_inexact(out_inexact[0]), .out_overflow(out_overflow[0])
  );

  fp_int2fp_seq #(.INT_W(16), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_int(in_int[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_fp(out_fp[1]),
    .out_inexact(out_inexact[1]), .out_overflow(out_overflow[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Value-level model: magnitude, leading-one position, integer RNE on the remainder.
  function automatic void ref_conv(input int sel, input logic [15:0] val,
                                   output logic [15:0] fp, output logic inx,
                                   output logic ovf, output int lat);
    int m, p, e, sh, q, rem, half;
    bit s;
    s   = (sel == 0) && val[15];
    m   = s ? (65536 - int'(val)) : int'(val);
    fp  = 16'h0000;
    inx = 1'b0;
    ovf = 1'b0;
    lat = 1;
    if (m == 0) return;
    p = 0;
    for (int i = 0; i < 17; i++) if (m >= (1 << i)) p = i;
    lat = 2 + (15 - p);
    e = p;
    if (p <= 10) begin
      q = m << (10 - p);
    end else begin
      sh   = p - 10;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      inx = (rem != 0);
    end
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e + 15 >= 31) begin
      ovf = 1'b1;
      fp  = {s, 5'h1F, 10'h000};
    end else begin
      fp = {s, 5'(e + 15), 10'(q - 1024)};
    end
  endfunction

  task automatic run_one(input int sel, input logic [15:0] val, input logic [15:0] efp,
                         input logic einx, input logic eovf, input int elat, input int hold);
    int lat;
    chk("in_ready_idle", 32'(in_ready[sel]), 32'd1);
    in_int[sel]   = val;
    in_valid[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    in_int[sel]   = 16'($urandom);
    lat = 1;
    while (!out_valid[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency[%0d:%h]", sel, val), 32'(lat), 32'(elat));
    if (hold > 0) begin
      in_int[sel]   = 16'h1234;
      in_valid[sel] = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_fp", 32'(out_fp[sel]), 32'(efp));
      chk("hold_in_ready", 32'(in_ready[sel]), 32'd0);
    end
    in_valid[sel] = 1'b0;
    chk($sformatf("fp[%0d:%h]", sel, val), 32'(out_fp[sel]), 32'(efp));
    chk($sformatf("inexact[%0d:%h]", sel, val), 32'(out_inexact[sel]), 32'(einx));
    chk($sformatf("overflow[%0d:%h]", sel, val), 32'(out_overflow[sel]), 32'(eovf));
    out_ready[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready[sel] = 1'b0;
    chk("out_valid_drop", 32'(out_valid[sel]), 32'd0);
    chk("in_ready_back", 32'(in_ready[sel]), 32'd1);
  endtask

  task automatic run_model(input int sel, input logic [15:0] val, input int hold);
    logic [15:0] efp;
    logic        einx, eovf;
    int          elat;
    ref_conv(sel, val, efp, einx, eovf, elat);
    run_one(sel, val, efp, einx, eovf, elat, hold);
  endtask

  initial begin
    int seen;
    logic [15:0] v;
    int sel;
    in_int[0] = 16'h0000;
    in_int[1] = 16'h0000;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_out_fp", 32'(out_fp[i]), 32'd0);
      chk("rst_flags", 32'({out_inexact[i], out_overflow[i]}), 32'd0);
    end
    rst = 1'b0;

    run_one(0, 16'h0001, 16'h3C00, 1'b0, 1'b0, 17, 0);
    run_one(0, 16'h8000, 16'hF800, 1'b0, 1'b0, 2, 0);
    run_one(0, 16'h7FFF, 16'h7800, 1'b1, 1'b0, 3, 0);
    run_one(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1, 0);
    run_one(0, 16'd2049, 16'h6800, 1'b1, 1'b0, 6, 0);
    run_one(0, 16'd2051, 16'h6802, 1'b1, 1'b0, 6, 0);
    run_one(0, 16'hFFFF, 16'hBC00, 1'b0, 1'b0, 17, 0);
    run_one(1, 16'hFFFF, 16'h7C00, 1'b1, 1'b1, 2, 0);
    run_one(1, 16'hFFE0, 16'h7BFF, 1'b0, 1'b0, 2, 0);
    run_one(1, 16'hFFF0, 16'h7C00, 1'b1, 1'b1, 2, 0);
    run_one(1, 16'h8000, 16'h7800, 1'b0, 1'b0, 2, 0);
    run_one(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1, 0);

    // Backpressure: result held, stray in_valid ignored.
    run_one(0, 16'd2051, 16'h6802, 1'b1, 1'b0, 6, 5);
    run_one(0, 16'h0005, 16'h4500, 1'b0, 1'b0, 15, 0);

    // Reset during normalization abandons the conversion.
    in_int[0]   = 16'h0001;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst_out_fp", 32'(out_fp[0]), 32'd0);
    chk("midrst_flags", 32'({out_inexact[0], out_overflow[0]}), 32'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    run_one(0, 16'h0003, 16'h4200, 1'b0, 1'b0, 16, 0);

    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 1));
      v   = 16'($urandom >> $urandom_range(16, 31));
      if (sel == 0 && $urandom_range(0, 1) == 1) v = -v;
      run_model(sel, v, int'($urandom_range(0, 3)));
    end
    run_model(0, 16'h8000, 1);
    run_model(1, 16'hFFEF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
